fp32_div_result_queue: RTL and testbench
========================================

Name: fp32_div_result_queue

Overview:
- Sits directly downstream of the combinational fp32 divider.
- Captures each divide result and its five IEEE-754 exception flags into a small in-order FIFO, and returns them to the consumer over a valid/ready handshake.
- Keeps the architectural sticky exception-flag register (fflags). Flags are OR-accumulated only when a result is consumed (committed), and the register is software-writable and clearable.

Parameters:
- DEPTH, 4, number of result entries; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  divider result valid.
- in_ready  output  1  queue can accept an entry.
- in_y  input  32  divider result word.
- in_exc  input  5  {invalid, divzero, overflow, underflow, inexact}, bit 4 down to bit 0.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head entry.
- out_y  output  32  head result.
- out_exc  output  5  head exception flags, same bit order as in_exc.
- fflags  output  5  sticky accumulated flags.
- fflags_wr  input  1  software write strobe.
- fflags_wdata  input  5  value to write.
- fflags_clr  input  1  software clear strobe.
- count  output  CNT_W  current occupancy.

Behaviour:
- Reset, asynchronous on rst high:
  - wr_ptr = 0, rd_ptr = 0, count = 0, fflags = 0.
  - out_valid = 0, out_y = 0, out_exc = 0.
  - in_ready = 0 while rst is high, and 1 from the first cycle after release.
  - Entry storage is not reset.
- Push = in_valid & in_ready. On push, write {in_y, in_exc} at wr_ptr and advance wr_ptr modulo DEPTH.
- Pop = out_valid & out_ready. On pop, advance rd_ptr modulo DEPTH.
- Pointer width is log2(DEPTH); wrap is natural overflow.
- in_ready = (count != DEPTH).
  - in_ready is a function of registered state only; there is no combinational path from out_ready.
  - When the queue is full, push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0).
- out_y and out_exc show the head entry's data when out_valid is 1, and are forced to 0 when out_valid is 0.
- Latency: an entry pushed in cycle N is visible at the output in cycle N+1. There is no fall-through when empty.
- Count update per cycle:
  - push only: count + 1.
  - pop only: count − 1.
  - push and pop together: count unchanged (only possible when 0 < count < DEPTH).
- Ordering: strict FIFO. No reordering and no drops.
- Upstream rule: in_y and in_exc must stay stable while in_valid = 1 and in_ready = 0. The bench checks this with an assertion.
- fflags next-state, where P = popped out_exc when a pop occurs, else 0:
  - fflags_wr = 1: fflags = fflags_wdata | P.
  - else fflags_clr = 1: fflags = P.
  - else: fflags = fflags | P.
  - Write has priority over clear. Flags popped in the same cycle are never lost.
- Flags are accumulated only on pop. Flags of entries still queued, or discarded by reset, never reach fflags.
- Reset mid-operation: all queued entries are discarded, count returns to 0, and fflags returns to 0.

Decomposition:
- Shared package fp32_pkg holds:
  - localparams EXC_NV = 4, EXC_DZ = 3, EXC_OF = 2, EXC_UF = 1, EXC_NX = 0.
  - typedef fp_exc_t = packed logic [4:0].
  - typedef fp32_res_t = packed struct {logic [31:0] y; fp_exc_t exc;}.
  - localparam QNAN_CANON = 32'h7fc00000.
- One natural sub-module, sync_fifo: a generic parameterised storage array with pointers and count, taking width and depth as parameters.
- fp32_div_result_queue instantiates sync_fifo with width 37 and adds the fflags logic and output masking.

Test Plan:
1. Reset release, then push in_y = 32'h3eaaaaab (1/3) with in_exc = 5'b00001 and out_ready = 1 → the next cycle shows out_valid = 1, out_y = 32'h3eaaaaab, out_exc = 5'b00001; after the pop, fflags = 5'b00001 and count = 0.
2. Hold out_ready = 0 and push 32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000 → count = 4 and in_ready = 0. Drive a fifth push (32'h40a00000) and pop in the same cycle → the fifth push is refused and count = 3. Remaining pops return the entries in push order.
3. Push 32'h7f800000 with 5'b01000 (x/0), then 32'h7fc00000 with 5'b10000 (0/0); pop both → fflags = 5'b11000. Pulse fflags_clr → fflags = 0.
4. In the same cycle as a pop of an entry with exc = 5'b00101, assert fflags_wr = 1 with fflags_wdata = 5'b00010 and fflags_clr = 1 → fflags = 5'b00111.
5. Push three entries with exc = 5'b11111 and out_ready = 0, then assert rst asynchronously mid-cycle → count = 0, out_valid = 0, out_y = 0, and in_ready = 0 during reset; after release, fflags = 0 and in_ready = 1.
6. Push and pop every cycle for 3·DEPTH + 1 entries with a counting pattern y = i → outputs appear in order across pointer wrap, count stays at 1, and there is no stall.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 definitions for the divider datapath.
// Exception flag bit positions, the flag vector type, the queued result
// record and the canonical quiet NaN encoding.
package fp32_pkg;

  localparam int EXC_NV = 4;  // invalid operation
  localparam int EXC_DZ = 3;  // divide by zero
  localparam int EXC_OF = 2;  // overflow
  localparam int EXC_UF = 1;  // underflow
  localparam int EXC_NX = 0;  // inexact

  typedef logic [4:0] fp_exc_t;

  typedef struct packed {
    logic [31:0] y;
    fp_exc_t     exc;
  } fp32_res_t;

  localparam logic [31:0] QNAN_CANON = 32'h7fc00000;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO storage with read/write pointers and occupancy.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   push      write wdata at the tail (caller guarantees not full)
//   wdata     entry to store
//   pop       drop the head entry (caller guarantees not empty)
//   rdata     head entry (storage contents, not masked)
//   count     current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // DEPTH is a power of two, so pointer wrap is plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fp32_div_result_queue.sv
// In-order result queue behind the combinational fp32 divider, plus the
// sticky architectural exception-flag register (fflags).
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           upstream handshake; in_y, in_exc = result
//   out_valid/out_ready         downstream handshake; out_y, out_exc = head
//   fflags                      sticky flags, accumulated on pop only
//   fflags_wr/fflags_wdata      software write (wins over clear)
//   fflags_clr                  software clear
//   count                       current occupancy
module fp32_div_result_queue
  import fp32_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic [4:0]       in_exc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [4:0]       out_exc,
  output logic [4:0]       fflags,
  input  logic             fflags_wr,
  input  logic [4:0]       fflags_wdata,
  input  logic             fflags_clr,
  output logic [CNT_W-1:0] count
);

  fp32_res_t  wr_ent;
  fp32_res_t  head;
  logic       push, pop;
  logic       alive_q;
  fp_exc_t    fflags_q, fflags_d;
  fp_exc_t    pop_exc;

  assign wr_ent = '{y: in_y, exc: in_exc};

  sync_fifo #(
    .WIDTH ($bits(fp32_res_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );

  // alive_q holds in_ready low during reset and rises on the first clock
  // after release; in_ready depends only on registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) alive_q <= 1'b0;
    else     alive_q <= 1'b1;
  end

  assign in_ready  = alive_q && (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage is never reset, so hide stale contents when empty.
  assign out_y   = out_valid ? head.y   : 32'h0;
  assign out_exc = out_valid ? head.exc : 5'h0;

  // Flags of the entry being popped this cycle are folded in on every
  // path, so a simultaneous write or clear never loses them.
  assign pop_exc = pop ? head.exc : 5'h0;

  always_comb begin
    fflags_d = fflags_q | pop_exc;
    if (fflags_wr)       fflags_d = fflags_wdata | pop_exc;
    else if (fflags_clr) fflags_d = pop_exc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fflags_q <= '0;
    else     fflags_q <= fflags_d;
  end

  assign fflags = fflags_q;

endmodule

// File: tb/tb_fp32_div_result_queue.sv
module tb_fp32_div_result_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_y = '0;
  logic [4:0]       in_exc = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_y;
  logic [4:0]       out_exc;
  logic [4:0]       fflags;
  logic             fflags_wr = 1'b0;
  logic [4:0]       fflags_wdata = '0;
  logic             fflags_clr = 1'b0;
  logic [CNT_W-1:0] count;

  fp32_div_result_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_y         (in_y),
    .in_exc       (in_exc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_y        (out_y),
    .out_exc      (out_exc),
    .fflags       (fflags),
    .fflags_wr    (fflags_wr),
    .fflags_wdata (fflags_wdata),
    .fflags_clr   (fflags_clr),
    .count        (count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of results plus the sticky flag value.
  typedef struct {
    logic [31:0] y;
    logic [4:0]  exc;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_ff = '0;
  bit         m_alive = 1'b0;
  bit         m_pushed = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  // Upstream stability rule: data must not change while stalled.
  logic        stall_q = 1'b0;
  logic [31:0] hold_y = '0;
  logic [4:0]  hold_exc = '0;
  always @(posedge clk) begin
    if (!rst && stall_q && in_valid)
      assert (in_y == hold_y && in_exc == hold_exc)
        else $error("upstream data changed while stalled");
    stall_q  <= in_valid && !in_ready && !rst;
    hold_y   <= in_y;
    hold_exc <= in_exc;
  end

  // One clock: check all outputs against the model mid-cycle, then advance
  // the model with the inputs currently driven.
  task automatic step();
    bit          rdy, push, pop;
    logic [31:0] ey;
    logic [4:0]  ee, p;
    @(negedge clk);
    rdy = m_alive && (q.size() != DEPTH);
    ey = '0;
    ee = '0;
    if (q.size() > 0) begin
      ey = q[0].y;
      ee = q[0].exc;
    end
    chk("in_ready",  in_ready,  rdy);
    chk("out_valid", out_valid, q.size() != 0);
    chk("out_y",     out_y,     ey);
    chk("out_exc",   out_exc,   ee);
    chk("count",     count,     q.size());
    chk("fflags",    fflags,    m_ff);
    push = in_valid && rdy && !rst;
    pop  = out_ready && (q.size() > 0) && !rst;
    p = pop ? ee : 5'b0;
    if (rst)             m_ff = '0;
    else if (fflags_wr)  m_ff = fflags_wdata | p;
    else if (fflags_clr) m_ff = p;
    else                 m_ff = m_ff | p;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back('{y: in_y, exc: in_exc});
    m_pushed = push;
    @(posedge clk);
    #1;
    if (!rst) m_alive = 1'b1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    out_ready = 1'b0;
    fflags_wr = 1'b0;
    fflags_clr = 1'b0;
  endtask

  logic [31:0] t2_vals [5];

  initial begin
    t2_vals[0] = 32'h3f800000;
    t2_vals[1] = 32'h40000000;
    t2_vals[2] = 32'h40400000;
    t2_vals[3] = 32'h40800000;
    t2_vals[4] = 32'h40a00000;

    // Power-on reset, checked while held, released mid-cycle.
    #2 rst = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    step();
    chk("rel_in_ready", in_ready, 1'b1);

    // 1: single 1/3 result, consumed as soon as visible.
    in_valid = 1'b1; in_y = 32'h3eaaaaab; in_exc = 5'b00001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_y",     out_y,     32'h3eaaaaab);
    chk("t1_exc",   out_exc,   5'b00001);
    step();
    chk("t1_fflags", fflags, 5'b00001);
    chk("t1_count",  count,  0);

    // 2: fill, refused push on full with simultaneous pop, ordered drain.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_y = t2_vals[i]; in_exc = 5'b00000;
      step();
    end
    in_valid = 1'b0;
    chk("t2_full_count", count, 4);
    chk("t2_full_rdy",   in_ready, 1'b0);
    in_valid = 1'b1; in_y = t2_vals[4]; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t2_refused_count", count, 3);
    for (int i = 1; i < 4; i++) begin
      chk("t2_order", out_y, t2_vals[i]);
      step();
    end
    chk("t2_empty", out_valid, 1'b0);

    // 3: x/0 and 0/0 flags accumulate, then clear.
    idle_inputs();
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    in_valid = 1'b1; in_y = 32'h7f800000; in_exc = 5'b01000;
    step();
    in_y = 32'h7fc00000; in_exc = 5'b10000;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    chk("t3_fflags", fflags, 5'b11000);
    out_ready = 1'b0; fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    chk("t3_clr", fflags, 5'b00000);

    // 4: write and clear together with a pop; write wins, pop flags kept.
    in_valid = 1'b1; in_y = 32'h3f000000; in_exc = 5'b00101;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    fflags_wr = 1'b1; fflags_wdata = 5'b00010; fflags_clr = 1'b1;
    step();
    idle_inputs();
    chk("t4_fflags", fflags, 5'b00111);

    // 5: asynchronous reset with queued entries carrying every flag.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_y = 32'h1000 + i; in_exc = 5'b11111;
      step();
    end
    in_valid = 1'b0;
    #3 rst = 1'b1;
    q.delete();
    m_ff = '0;
    m_alive = 1'b0;
    #1;
    chk("t5_count",  count,     0);
    chk("t5_valid",  out_valid, 1'b0);
    chk("t5_y",      out_y,     32'h0);
    chk("t5_rdy",    in_ready,  1'b0);
    chk("t5_fflags", fflags,    5'b00000);
    step();
    #2 rst = 1'b0;
    step();
    chk("t5_rel_rdy",    in_ready, 1'b1);
    chk("t5_rel_fflags", fflags,   5'b00000);

    // 6: streaming push+pop every cycle across several pointer wraps.
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH + 1; i++) begin
      in_valid = 1'b1; in_y = i; in_exc = 5'b00000;
      step();
      chk("t6_count", count, 1);
      chk("t6_nostall", m_pushed, 1'b1);
      chk("t6_head", out_y, i);
    end
    in_valid = 1'b0;
    step();

    // Randomized traffic against the model.
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !m_pushed)) begin
        in_valid = ($urandom_range(0, 9) < 6);
        in_y     = $urandom;
        in_exc   = 5'($urandom);
      end
      out_ready    = ($urandom_range(0, 9) < 5);
      fflags_wr    = ($urandom_range(0, 15) == 0);
      fflags_wdata = 5'($urandom);
      fflags_clr   = ($urandom_range(0, 15) == 0);
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) step();
    chk("drain_count", count, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
